// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the output-stationary systolic array:
//   - sa_state_e   : sequencing FSM states (IDLE/LOAD/DRAIN/OUT)
//   - SA_*         : default geometry and width constants
//   - sa_out_conv  : accumulator-to-output element conversion
// Build option: SA_OUT_SAT_EN selects unsigned saturation of each output
// element; without it the element is the low DATA_W bits of the accumulator.
// ---------------------------------------------------------------------------
package sa_pkg;

  localparam int SA_ROWS   = 2;
  localparam int SA_COLS   = 2;
  localparam int SA_DATA_W = 8;
  localparam int SA_ACC_W  = 20;
  localparam int SA_K_MAX  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } sa_state_e;

  // Works on a 64-bit container so one function serves every DATA_W/ACC_W;
  // the caller narrows the result to DATA_W.
  function automatic logic [63:0] sa_out_conv(input logic [63:0] acc,
                                              input int unsigned dw);
    logic [63:0] max_v;
    max_v = (64'd1 << dw) - 64'd1;
`ifdef SA_OUT_SAT_EN
    return (acc > max_v) ? max_v : acc;
`else
    return acc & max_v;
`endif
  endfunction

endpackage

// File: rtl/sa_os_array_if.sv
// ---------------------------------------------------------------------------
// sa_os_array_if
// Operand/result bus of the systolic array.
//   start, k_len          : job launch and inner dimension
//   a_valid/a_ready       : operand beat handshake, a_row (A column k),
//                           b_col (B row k)
//   c_valid/c_ready       : result row handshake, c_data, c_row
//   busy, done            : job status
// master = operand/result side, slave = the array.
// ---------------------------------------------------------------------------
interface sa_os_array_if #(
  parameter int ROWS   = 2,
  parameter int COLS   = 2,
  parameter int DATA_W = 8,
  parameter int K_MAX  = 16
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                     start;
  logic [KW-1:0]            k_len;
  logic                     a_valid;
  logic                     a_ready;
  logic [ROWS*DATA_W-1:0]   a_row;
  logic [COLS*DATA_W-1:0]   b_col;
  logic                     c_valid;
  logic                     c_ready;
  logic [COLS*DATA_W-1:0]   c_data;
  logic [RW-1:0]            c_row;
  logic                     busy;
  logic                     done;

  modport master (
    output start, k_len, a_valid, a_row, b_col, c_ready,
    input  a_ready, c_valid, c_data, c_row, busy, done
  );

  modport slave (
    input  start, k_len, a_valid, a_row, b_col, c_ready,
    output a_ready, c_valid, c_data, c_row, busy, done
  );
endinterface

// File: rtl/sa_pe.sv
// ---------------------------------------------------------------------------
// sa_pe
// One processing element of the output-stationary grid.
//   clk, reset  : clock, asynchronous active-high reset
//   clr_i       : synchronous clear of accumulator and pass-through regs
//   a_i, b_i    : operands arriving from the left / from above
//   a_o, b_o    : registered copies forwarded right / downward
//   acc_o       : running sum of a*b (full product, modulo 2^ACC_W)
// ---------------------------------------------------------------------------
module sa_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] a_o,
  output logic [DATA_W-1:0] b_o,
  output logic [ACC_W-1:0]  acc_o
);
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [ACC_W-1:0]    acc_q;

  assign prod = a_i * b_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/sa_os_array.sv
// ---------------------------------------------------------------------------
// sa_os_array
// Output-stationary systolic array computing C = A*B (ROWS x K by K x COLS,
// unsigned). A flows right, B flows down; each PE keeps one C element.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sa_os_array_if.slave (start/k_len, operand beats a_row/b_col
//                with a_valid/a_ready, result rows c_data/c_row with
//                c_valid/c_ready, busy, done)
// Build option: SA_OUT_SAT_EN (see sa_pkg::sa_out_conv).
// ---------------------------------------------------------------------------
module sa_os_array
  import sa_pkg::*;
#(
  parameter int ROWS   = SA_ROWS,
  parameter int COLS   = SA_COLS,
  parameter int DATA_W = SA_DATA_W,
  parameter int ACC_W  = SA_ACC_W,
  parameter int K_MAX  = SA_K_MAX
) (
  input  logic          clk,
  input  logic          reset,
  sa_os_array_if.slave  bus
);
  localparam int KW      = $clog2(K_MAX + 1);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DRAIN_N = ROWS + COLS - 1;
  localparam int CW      = $clog2(K_MAX + DRAIN_N + 1);

  sa_state_e         state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic              clr, fire, a_ready, c_valid, done;
  logic [COLS*DATA_W-1:0] c_data;

  logic [DATA_W-1:0] a_lnk [ROWS][COLS+1];
  logic [DATA_W-1:0] b_lnk [ROWS+1][COLS];
  logic [ACC_W-1:0]  acc   [ROWS][COLS];

  // ---- sequencing FSM ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    clr     = 1'b0;
    a_ready = 1'b0;
    c_valid = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          cnt_d   = '0;
          row_d   = '0;
          k_d     = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
          state_d = (bus.k_len == '0) ? DRAIN : LOAD;
        end
      end
      LOAD: begin
        a_ready = 1'b1;
        if (bus.a_valid) begin
          if (cnt_q == CW'(k_q) - CW'(1)) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        // Wait until the last beat has crossed to PE(ROWS-1, COLS-1).
        if (cnt_q == CW'(DRAIN_N - 1)) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUT: begin
        c_valid = 1'b1;
        if (bus.c_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            done    = 1'b1;
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gaps in LOAD feed zeros, which add nothing to any accumulator.
  assign fire = (state_q == LOAD) && bus.a_valid;

  // ---- input capture + skew ----
  // Stage [0] captures the accepted beat; element i then sees i more
  // registers so that A[i][k] and B[k][j] meet in PE(i,j) on the same edge.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    logic [DATA_W-1:0] sk_q [0:i];
    always_ff @(posedge clk or posedge reset) begin
      if (reset || clr) begin
        for (int d = 0; d <= i; d++) sk_q[d] <= '0;
      end else begin
        sk_q[0] <= fire ? bus.a_row[i*DATA_W +: DATA_W] : '0;
        for (int d = 1; d <= i; d++) sk_q[d] <= sk_q[d-1];
      end
    end
    assign a_lnk[i][0] = sk_q[i];
    logic unused_a_edge;
    assign unused_a_edge = ^a_lnk[i][COLS];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    logic [DATA_W-1:0] sk_q [0:j];
    always_ff @(posedge clk or posedge reset) begin
      if (reset || clr) begin
        for (int d = 0; d <= j; d++) sk_q[d] <= '0;
      end else begin
        sk_q[0] <= fire ? bus.b_col[j*DATA_W +: DATA_W] : '0;
        for (int d = 1; d <= j; d++) sk_q[d] <= sk_q[d-1];
      end
    end
    assign b_lnk[0][j] = sk_q[j];
    logic unused_b_edge;
    assign unused_b_edge = ^b_lnk[ROWS][j];
  end

  // ---- PE grid ----
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      sa_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr),
        .a_i   (a_lnk[i][j]),
        .b_i   (b_lnk[i][j]),
        .a_o   (a_lnk[i][j+1]),
        .b_o   (b_lnk[i+1][j]),
        .acc_o (acc[i][j])
      );
    end
  end

  // ---- result row mux ----
  // Accumulators are frozen in OUT, so c_data holds across a stall.
  always_comb begin
    c_data = '0;
    if (state_q == OUT) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_q == RW'(r)) begin
          for (int j = 0; j < COLS; j++)
            c_data[j*DATA_W +: DATA_W] = DATA_W'(sa_out_conv(64'(acc[r][j]), DATA_W));
        end
      end
    end
  end

  assign bus.a_ready = a_ready;
  assign bus.c_valid = c_valid;
  assign bus.c_data  = c_data;
  assign bus.c_row   = row_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done;
endmodule

// File: doc/sa_os_array.md
# sa_os_array

Parametrised output-stationary systolic array computing C = A·B for a ROWS×K by K×COLS unsigned matrix product. It replaces the fixed 2×2 independent-PE array with a true systolic grid:
- A operands flow right and B operands flow down through registered PE-to-PE links.
- Input skew and the run/drain/readout sequencing are generated internally.
- Results leave row by row over a valid/ready handshake.

It sits between the memory/controller front end (operand streaming) and the result write-back path.

## Interface
- ROWS, default 2: PE grid rows (≥1).
- COLS, default 2: PE grid columns (≥1).
- DATA_W, default 8: operand and output element width, unsigned.
- ACC_W, default 20: accumulator width; must be ≥ 2·DATA_W + $clog2(K_MAX).
- K_MAX, default 16: maximum inner dimension.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a job; sampled only in IDLE.
- k_len  in  $clog2(K_MAX+1)  inner dimension K, latched on start.
- a_valid  in  1  operand beat valid.
- a_ready  out  1  operand beat accepted when a_valid && a_ready.
- a_row  in  ROWS·DATA_W  beat k: element i = A[i][k].
- b_col  in  COLS·DATA_W  beat k: element j = B[k][j].
- c_valid  out  1  result row valid.
- c_ready  in  1  downstream accepts row.
- c_data  out  COLS·DATA_W  element j = C[c_row][j] after output conversion.
- c_row  out  $clog2(ROWS) (min 1)  index of the row on c_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the final row handshake.

## Operation
- The FSM has four states: IDLE, LOAD, DRAIN and OUT.
- IDLE:
  - On start, latch k_len and clear all accumulators and skew/link registers.
  - If k_len≠0, go to LOAD; if k_len=0, go to DRAIN (result is all zeros).
- LOAD:
  - a_ready=1.
  - A beat counter increments per accepted beat.
  - After accepting beat k_len−1, go to DRAIN.
  - Cycles with a_valid=0 inject zero operands, which contribute nothing to the sums.
- DRAIN:
  - a_ready=0.
  - A counter runs ROWS+COLS−1 cycles, then the FSM goes to OUT.
- OUT:
  - c_valid=1, starting with c_row=0.
  - Each c_valid && c_ready advances c_row.
  - The handshake on row ROWS−1 pulses done and returns to IDLE.
  - c_data is held stable while c_valid && !c_ready.
- Skew: A element i passes through i registers before entering column 0; B element j passes through j registers before entering row 0.
- PE(i,j) operation:
  - acc += a·b, with a full 2·DATA_W-bit product, zero-extended and added modulo 2^ACC_W.
  - It forwards a to the right and b downward, each through one register.
- start outside IDLE is ignored; k_len > K_MAX is clamped to K_MAX.
- Reset mid-job returns to IDLE immediately. No partial results or done pulse are emitted.

## Timing
- A beat accepted at edge n is accumulated by PE(i,j) at edge n+1+i+j.
- Last accumulation completes at edge e+ROWS+COLS−1, where e is the last-beat edge. DRAIN covers exactly this interval.
- start at edge s:
  - LOAD begins at s+1 and a_ready is high in cycle s+1.
  - Minimum job length is 1 + K + (ROWS+COLS−1) + ROWS cycles with a_valid and c_ready held high.
- Reset values:
  - a_ready=0, c_valid=0, c_data=0, c_row=0, busy=0, done=0.
  - All accumulators and link registers are 0.
- c_data, c_row and c_valid are registered or driven directly from state and accumulators. There is no combinational path from c_ready to c_valid.

## Configuration
- SA_OUT_SAT_EN defined: each output element is min(acc, 2^DATA_W−1), an unsigned saturation.
- SA_OUT_SAT_EN undefined: each output element is acc[DATA_W−1:0], a truncation.
- Accumulator arithmetic is identical in both builds.

## Structure
- Package sa_pkg holds:
  - The FSM state enum (IDLE/LOAD/DRAIN/OUT).
  - The default width constants.
  - The output conversion function, which contains the only SA_OUT_SAT_EN-guarded code.
- Sub-module sa_pe contains:
  - The registered MAC.
  - Synchronous clear.
  - a/b pass-through registers.
- The top level handles generate-instantiation of the ROWS×COLS grid, the skew registers, the FSM and the output mux.

## Test plan
- 2×2, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], c_ready=1 → row0 = {19,22}, row1 = {43,50}, done pulses once, and total job length is 1+2+3+2 cycles.
- Same job with a_valid low on alternate cycles and c_ready low for 3 cycles on row 0 → identical results, and c_data stable during the stall.
- 1×1, K=16, all operands 255 → acc = 1040400. Output is 255 with SA_OUT_SAT_EN and 16 without it.
- k_len=0 → LOAD is skipped, all rows read 0, done asserted. A start pulse while busy → no effect on the running job.
- reset asserted during DRAIN → all outputs at reset values the same cycle. The next job (2×2 case above) gives correct results with no residue.
- ROWS=4, COLS=3, K=5, random operands → all 4 rows match the reference model in order c_row = 0..3.
